// File: rtl/dp_sequencer_if.sv
// Instruction handshake, ALU status and datapath control word for dp_sequencer.
// No logic; the sequencer uses the slave modport and its driver uses the master modport.
// The handshake is valid/ready: instr is taken on any edge where instr_valid and instr_ready are both high.
interface dp_sequencer_if;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [3:0]  status;
  logic [4:0]  fs;
  logic [4:0]  addrR;
  logic [4:0]  addrA;
  logic [4:0]  addrB;
  logic [63:0] k;
  logic        s;
  logic        sd;
  logic        sb;
  logic        c0;
  logic        w;
  logic [3:0]  flags;
  logic        op_done;
  logic        illegal;

  modport slave (
    input  instr, instr_valid, status,
    output instr_ready, fs, addrR, addrA, addrB, k, s, sd, sb, c0, w,
           flags, op_done, illegal
  );

  modport master (
    output instr, instr_valid, status,
    input  instr_ready, fs, addrR, addrA, addrB, k, s, sd, sb, c0, w,
           flags, op_done, illegal
  );
endinterface

// File: rtl/dp_sequencer.sv
// Decodes instruction words into a registered ALU/register-file control word; SWAP runs as a 3-cycle XOR swap.
// Latency: an instruction accepted at edge N has its control word valid in cycle N+1; write and flag capture happen at edge N+2.
// Backpressure: instr_ready is low in SW1 and SW2 only; single-cycle ops accept one instruction per clock.
module dp_sequencer #(
  parameter logic [4:0] FS_ADD = 5'b01000,
  parameter logic [4:0] FS_AND = 5'b00000,
  parameter logic [4:0] FS_ORR = 5'b00100,
  parameter logic [4:0] FS_EOR = 5'b01100,
  parameter logic [4:0] FS_SUB = 5'b01001
) (
  input logic           clk,
  input logic           rst,
  dp_sequencer_if.slave bus
);

  typedef enum logic [2:0] {IDLE, EXEC, SW1, SW2, SW3} state_t;

  typedef struct packed {
    logic [4:0]  fs;
    logic [4:0]  addr_r;
    logic [4:0]  addr_a;
    logic [4:0]  addr_b;
    logic [11:0] imm;
    logic        s;
    logic        sd;
    logic        sb;
    logic        c0;
    logic        w;
    logic        op_done;
    logic        illegal;
    logic        flag_en;
  } ctrl_t;

  state_t     state_q, state_d;
  ctrl_t      ctrl_q, ctrl_d;
  logic [4:0] rd_q, rn_q;
  logic [3:0] flags_q;
  logic       hs;

  logic [3:0] op;
  logic       setf;
  logic [4:0] rd, rn, rm;
  logic [11:0] imm;

  assign op   = bus.instr[31:28];
  assign setf = bus.instr[27];
  assign rd   = bus.instr[26:22];
  assign rn   = bus.instr[21:17];
  assign rm   = bus.instr[16:12];
  assign imm  = bus.instr[11:0];

  assign bus.instr_ready = (state_q != SW1) && (state_q != SW2);
  assign hs = bus.instr_valid && bus.instr_ready;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state and next control word; the SWAP steps reuse the rd/rn captured at the handshake.
  always_comb begin
    state_d = IDLE;
    ctrl_d  = '0;
    case (state_q)
      IDLE, EXEC, SW3: begin
        if (hs) begin
          state_d        = EXEC;
          ctrl_d.op_done = 1'b1;
          case (op)
            4'd0: ;
            4'd1, 4'd2, 4'd3, 4'd4: begin
              ctrl_d.fs      = (op == 4'd1) ? FS_ADD : (op == 4'd2) ? FS_SUB :
                               (op == 4'd3) ? FS_AND : FS_ORR;
              ctrl_d.addr_r  = rd;
              ctrl_d.addr_a  = rn;
              ctrl_d.addr_b  = rm;
              ctrl_d.c0      = (op == 4'd2);
              ctrl_d.sd      = 1'b1;
              ctrl_d.w       = 1'b1;
              ctrl_d.flag_en = setf;
            end
            4'd5: begin
              ctrl_d.fs      = FS_ADD;
              ctrl_d.addr_r  = rd;
              ctrl_d.addr_a  = rn;
              ctrl_d.imm     = imm;
              ctrl_d.s       = 1'b1;
              ctrl_d.sd      = 1'b1;
              ctrl_d.w       = 1'b1;
              ctrl_d.flag_en = setf;
            end
            4'd6: begin
              // Register 31 reads as zero, so ORR with it passes the constant through.
              ctrl_d.fs     = FS_ORR;
              ctrl_d.addr_r = rd;
              ctrl_d.addr_a = 5'd31;
              ctrl_d.imm    = imm;
              ctrl_d.s      = 1'b1;
              ctrl_d.sd     = 1'b1;
              ctrl_d.w      = 1'b1;
            end
            4'd7: begin
              ctrl_d.addr_r = rd;
              ctrl_d.addr_b = rm;
              ctrl_d.sb     = 1'b1;
              ctrl_d.w      = 1'b1;
            end
            4'd8: begin
              ctrl_d.fs      = FS_SUB;
              ctrl_d.addr_a  = rn;
              ctrl_d.addr_b  = rm;
              ctrl_d.c0      = 1'b1;
              ctrl_d.flag_en = 1'b1;
            end
            4'd9: begin
              // A self-swap would zero the register, so rd==rn degrades to a NOP.
              if (rd != rn) begin
                state_d        = SW1;
                ctrl_d.op_done = 1'b0;
                ctrl_d.fs      = FS_EOR;
                ctrl_d.addr_r  = rd;
                ctrl_d.addr_a  = rd;
                ctrl_d.addr_b  = rn;
                ctrl_d.sd      = 1'b1;
                ctrl_d.w       = 1'b1;
              end
            end
            default: ctrl_d.illegal = 1'b1;
          endcase
        end
      end
      SW1: begin
        state_d       = SW2;
        ctrl_d.fs     = FS_EOR;
        ctrl_d.addr_r = rn_q;
        ctrl_d.addr_a = rd_q;
        ctrl_d.addr_b = rn_q;
        ctrl_d.sd     = 1'b1;
        ctrl_d.w      = 1'b1;
      end
      SW2: begin
        state_d        = SW3;
        ctrl_d.fs      = FS_EOR;
        ctrl_d.addr_r  = rd_q;
        ctrl_d.addr_a  = rd_q;
        ctrl_d.addr_b  = rn_q;
        ctrl_d.sd      = 1'b1;
        ctrl_d.w       = 1'b1;
        ctrl_d.op_done = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered control word plus the SWAP operands captured at the handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q <= '0;
      rd_q   <= '0;
      rn_q   <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      if (hs) begin
        rd_q <= rd;
        rn_q <= rn;
      end
    end
  end

  // Flags follow the ALU status at the close of a flag-setting execute cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 flags_q <= '0;
    else if (ctrl_q.flag_en) flags_q <= bus.status;
  end

  assign bus.fs      = ctrl_q.fs;
  assign bus.addrR   = ctrl_q.addr_r;
  assign bus.addrA   = ctrl_q.addr_a;
  assign bus.addrB   = ctrl_q.addr_b;
  assign bus.k       = {52'b0, ctrl_q.imm};
  assign bus.s       = ctrl_q.s;
  assign bus.sd      = ctrl_q.sd;
  assign bus.sb      = ctrl_q.sb;
  assign bus.c0      = ctrl_q.c0;
  assign bus.w       = ctrl_q.w;
  assign bus.flags   = flags_q;
  assign bus.op_done = ctrl_q.op_done;
  assign bus.illegal = ctrl_q.illegal;

endmodule

// File: tb/tb_dp_sequencer.sv
// Directed bench for dp_sequencer: reset, back-to-back ops, flags, SWAP, MOV, illegal op, reset mid-SWAP.
// Inputs change 1ns after the rising edge; outputs are sampled at that same point.
// sd&sb exclusivity is checked on every falling edge.
module tb_dp_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  dp_sequencer_if bus();

  dp_sequencer dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk(input logic [3:0] op, input logic setf, input logic [4:0] rd,
                                     input logic [4:0] rn, input logic [4:0] rm, input logic [11:0] imm);
    return {op, setf, rd, rn, rm, imm};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // sd and sb must never both drive d.
  always @(negedge clk) check("sd_sb_excl", 64'(bus.sd & bus.sb), 0);

  initial begin
    bus.instr       = '0;
    bus.instr_valid = 1'b0;
    bus.status      = '0;

    // Reset state.
    tick(); tick();
    check("rst_w", 64'(bus.w), 0);
    check("rst_fs", 64'(bus.fs), 0);
    check("rst_flags", 64'(bus.flags), 0);
    check("rst_op_done", 64'(bus.op_done), 0);
    rst = 1'b0;
    tick();
    check("ready_after_rst", 64'(bus.instr_ready), 1);

    // ADD r1,r2,r3 then ADDI r4,r1,#5 back-to-back.
    bus.instr = mk(4'd1, 1'b0, 5'd1, 5'd2, 5'd3, 12'd0);
    bus.instr_valid = 1'b1;
    tick();
    check("add_fs", 64'(bus.fs), 5'b01000);
    check("add_addrR", 64'(bus.addrR), 1);
    check("add_addrA", 64'(bus.addrA), 2);
    check("add_addrB", 64'(bus.addrB), 3);
    check("add_sd", 64'(bus.sd), 1);
    check("add_w", 64'(bus.w), 1);
    check("add_s", 64'(bus.s), 0);
    check("add_op_done", 64'(bus.op_done), 1);
    bus.instr = mk(4'd5, 1'b0, 5'd4, 5'd1, 5'd0, 12'd5);
    tick();
    check("addi_s", 64'(bus.s), 1);
    check("addi_k", bus.k, 5);
    check("addi_addrR", 64'(bus.addrR), 4);
    check("addi_addrA", 64'(bus.addrA), 1);
    check("addi_fs", 64'(bus.fs), 5'b01000);
    bus.instr_valid = 1'b0;
    tick();
    check("idle_w", 64'(bus.w), 0);
    check("idle_op_done", 64'(bus.op_done), 0);

    // CMP r5,r6 sets flags; a following ADD without setf leaves them.
    bus.instr = mk(4'd8, 1'b0, 5'd0, 5'd5, 5'd6, 12'd0);
    bus.status = 4'b1010;
    bus.instr_valid = 1'b1;
    tick();
    check("cmp_w", 64'(bus.w), 0);
    check("cmp_c0", 64'(bus.c0), 1);
    check("cmp_fs", 64'(bus.fs), 5'b01001);
    check("cmp_sd", 64'(bus.sd), 0);
    check("cmp_flags_pre", 64'(bus.flags), 0);
    bus.instr = mk(4'd1, 1'b0, 5'd1, 5'd2, 5'd3, 12'd0);
    tick();
    check("cmp_flags", 64'(bus.flags), 4'b1010);
    bus.status = 4'b0001;
    bus.instr_valid = 1'b0;
    tick();
    check("add_nosetf_flags", 64'(bus.flags), 4'b1010);

    // ADD with setf captures status.
    bus.instr = mk(4'd1, 1'b1, 5'd1, 5'd2, 5'd3, 12'd0);
    bus.status = 4'b0101;
    bus.instr_valid = 1'b1;
    tick();
    bus.instr_valid = 1'b0;
    tick();
    check("add_setf_flags", 64'(bus.flags), 4'b0101);

    // SWAP rd=2, rn=7; a MOV r9,r4 waits on valid and is taken in SW3.
    bus.instr = mk(4'd9, 1'b0, 5'd2, 5'd7, 5'd0, 12'd0);
    bus.instr_valid = 1'b1;
    tick();
    check("sw1_fs", 64'(bus.fs), 5'b01100);
    check("sw1_addr", 64'({bus.addrR, bus.addrA, bus.addrB}), {5'd2, 5'd2, 5'd7});
    check("sw1_ready", 64'(bus.instr_ready), 0);
    check("sw1_op_done", 64'(bus.op_done), 0);
    check("sw1_w", 64'(bus.w), 1);
    bus.instr = mk(4'd7, 1'b0, 5'd9, 5'd0, 5'd4, 12'd0);
    tick();
    check("sw2_fs", 64'(bus.fs), 5'b01100);
    check("sw2_addr", 64'({bus.addrR, bus.addrA, bus.addrB}), {5'd7, 5'd2, 5'd7});
    check("sw2_ready", 64'(bus.instr_ready), 0);
    check("sw2_op_done", 64'(bus.op_done), 0);
    tick();
    check("sw3_fs", 64'(bus.fs), 5'b01100);
    check("sw3_addr", 64'({bus.addrR, bus.addrA, bus.addrB}), {5'd2, 5'd2, 5'd7});
    check("sw3_ready", 64'(bus.instr_ready), 1);
    check("sw3_op_done", 64'(bus.op_done), 1);
    check("sw3_sd", 64'(bus.sd), 1);
    tick();
    check("mov_sb", 64'(bus.sb), 1);
    check("mov_sd", 64'(bus.sd), 0);
    check("mov_addrB", 64'(bus.addrB), 4);
    check("mov_addrR", 64'(bus.addrR), 9);
    check("mov_w", 64'(bus.w), 1);

    // SWAP rd=rn=3 is a single NOP cycle.
    bus.instr = mk(4'd9, 1'b0, 5'd3, 5'd3, 5'd0, 12'd0);
    tick();
    check("swnop_w", 64'(bus.w), 0);
    check("swnop_op_done", 64'(bus.op_done), 1);
    check("swnop_ready", 64'(bus.instr_ready), 1);
    check("swnop_fs", 64'(bus.fs), 0);

    // Op 12 is illegal and runs as a NOP.
    bus.instr = mk(4'd12, 1'b0, 5'd1, 5'd2, 5'd3, 12'd0);
    tick();
    check("ill_illegal", 64'(bus.illegal), 1);
    check("ill_w", 64'(bus.w), 0);
    check("ill_op_done", 64'(bus.op_done), 1);
    bus.instr_valid = 1'b0;
    tick();
    check("ill_clear", 64'(bus.illegal), 0);

    // Reset mid-SWAP clears outputs without a clock edge.
    bus.instr = mk(4'd9, 1'b0, 5'd1, 5'd2, 5'd0, 12'd0);
    bus.instr_valid = 1'b1;
    tick();
    bus.instr_valid = 1'b0;
    check("sw_pre_rst_w", 64'(bus.w), 1);
    #2 rst = 1'b1;
    #1;
    check("midrst_w", 64'(bus.w), 0);
    check("midrst_fs", 64'(bus.fs), 0);
    check("midrst_addrR", 64'(bus.addrR), 0);
    check("midrst_flags", 64'(bus.flags), 0);
    check("midrst_ready", 64'(bus.instr_ready), 1);
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_ready", 64'(bus.instr_ready), 1);
    check("post_rst_w", 64'(bus.w), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
